// File: rtl/k12a_mem_arbiter.sv
// Two-port memory arbiter: CPU (fixed priority) and DMA share one RAM/ROM port,
// one access per three cycles. Optional stall counter under K12A_MEM_ARB_STATS_EN.
module k12a_mem_arbiter #(
  parameter int DMA_MAX_WAIT = 4
) (
  input  logic        cpu_clock,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic        mem_enable,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        owner,
`ifdef K12A_MEM_ARB_STATS_EN
  output logic [15:0] cpu_stall_cycles,
`endif
  output logic [1:0]  state_dbg
);

  // Handshake: a requester raises req with we/addr/wdata stable and holds all of
  // them until its one-cycle ack; req is only sampled in IDLE, so a req still
  // high after the ack cycle starts a new access.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] MAX_WAIT = 4'(DMA_MAX_WAIT);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt;
  logic       mem_write_q;
  logic       grant_any;
  logic       grant_dma;

  always_comb begin
    state_nxt  = state;
    grant_any  = 1'b0;
    grant_dma  = 1'b0;
    mem_enable = 1'b0;
    mem_write  = 1'b0;
    cpu_ack    = 1'b0;
    dma_ack    = 1'b0;
    busy       = (state != IDLE);
    state_dbg  = state;
    case (state)
      IDLE: begin
        if (cpu_req || dma_req) begin
          grant_any = 1'b1;
          // DMA wins when alone, or when it has lost MAX_WAIT contended rounds
          grant_dma = dma_req && (!cpu_req || (wait_cnt == MAX_WAIT));
          state_nxt = ACC;
        end
      end
      ACC: begin
        mem_enable = 1'b1;
        mem_write  = mem_write_q;
        state_nxt  = DONE;
      end
      DONE: begin
        cpu_ack   = ~owner;
        dma_ack   = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      owner       <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr    <= 16'd0;
      mem_wdata   <= 8'd0;
      cpu_rdata   <= 8'd0;
      dma_rdata   <= 8'd0;
    end else begin
      state <= state_nxt;
      if (grant_any) begin
        owner <= grant_dma;
        if (grant_dma) begin
          wait_cnt    <= 4'd0;
          mem_write_q <= dma_we;
          mem_addr    <= dma_addr;
          mem_wdata   <= dma_wdata;
        end else begin
          if (dma_req) wait_cnt <= wait_cnt + 4'd1;
          mem_write_q <= cpu_we;
          mem_addr    <= cpu_addr;
          mem_wdata   <= cpu_wdata;
        end
      end
      // Read data lands at the edge closing the access cycle
      if ((state == ACC) && !mem_write_q) begin
        if (owner) dma_rdata <= mem_rdata;
        else       cpu_rdata <= mem_rdata;
      end
    end
  end

`ifdef K12A_MEM_ARB_STATS_EN
  logic cpu_stalled;
  assign cpu_stalled = cpu_req && ((busy && owner) || grant_dma);

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      cpu_stall_cycles <= 16'd0;
    end else if (cpu_stalled && (cpu_stall_cycles != 16'hFFFF)) begin
      cpu_stall_cycles <= cpu_stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_k12a_mem_arbiter.sv
// Directed bench for k12a_mem_arbiter: reset, CPU/DMA accesses, starvation bound,
// reset mid-access and back-to-back CPU accesses.
module tb_k12a_mem_arbiter;

  logic        cpu_clock;
  logic        reset_n;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        dma_req, dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic        mem_enable, mem_write;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy, owner;
  logic [1:0]  state_dbg;
`ifdef K12A_MEM_ARB_STATS_EN
  logic [15:0] cpu_stall_cycles;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  k12a_mem_arbiter #(.DMA_MAX_WAIT(4)) dut (
    .cpu_clock (cpu_clock),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .mem_enable(mem_enable),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .owner     (owner),
`ifdef K12A_MEM_ARB_STATS_EN
    .cpu_stall_cycles(cpu_stall_cycles),
`endif
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial cpu_clock = 1'b0;
  always #5 cpu_clock = ~cpu_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge cpu_clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0; dma_wdata = 8'h0;
    mem_rdata = 8'h00;
    repeat (3) @(posedge cpu_clock);
    #1;
    vec_cnt++; if (busy !== 1'b0 || state_dbg !== 2'd0) begin err_cnt++; $display("FAIL rst_state: busy=%b state=%0d expected 0/0", busy, state_dbg); end
    vec_cnt++; if (owner !== 1'b0) begin err_cnt++; $display("FAIL rst_owner: got %b expected 0", owner); end
    vec_cnt++; if ({cpu_ack, dma_ack, mem_enable, mem_write} !== 4'b0) begin err_cnt++; $display("FAIL rst_strobes: got %b expected 0000", {cpu_ack, dma_ack, mem_enable, mem_write}); end
    vec_cnt++; if ({mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== 40'h0) begin err_cnt++; $display("FAIL rst_data: got %h expected 0", {mem_addr, mem_wdata, cpu_rdata, dma_rdata}); end
    @(negedge cpu_clock);
    reset_n = 1'b1;
  endtask

  task automatic test_cpu_read();
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234; mem_rdata = 8'hA5;
    tick();
    vec_cnt++; if (mem_enable !== 1'b1 || mem_write !== 1'b0) begin err_cnt++; $display("FAIL cpu_rd_acc: en=%b wr=%b expected 1/0", mem_enable, mem_write); end
    vec_cnt++; if (mem_addr !== 16'h1234) begin err_cnt++; $display("FAIL cpu_rd_addr: got %h expected 1234", mem_addr); end
    vec_cnt++; if (cpu_ack !== 1'b0 || owner !== 1'b0) begin err_cnt++; $display("FAIL cpu_rd_early: ack=%b owner=%b expected 0/0", cpu_ack, owner); end
    tick();
    vec_cnt++; if (cpu_ack !== 1'b1 || dma_ack !== 1'b0) begin err_cnt++; $display("FAIL cpu_rd_ack: cpu=%b dma=%b expected 1/0", cpu_ack, dma_ack); end
    vec_cnt++; if (cpu_rdata !== 8'hA5) begin err_cnt++; $display("FAIL cpu_rd_data: got %h expected a5", cpu_rdata); end
    vec_cnt++; if (mem_enable !== 1'b0) begin err_cnt++; $display("FAIL cpu_rd_done_en: got %b expected 0", mem_enable); end
    cpu_req = 1'b0;
    tick();
    vec_cnt++; if (busy !== 1'b0 || cpu_ack !== 1'b0) begin err_cnt++; $display("FAIL cpu_rd_idle: busy=%b ack=%b expected 0/0", busy, cpu_ack); end
  endtask

  task automatic test_dma_write();
    tick();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h8001; dma_wdata = 8'h3C; mem_rdata = 8'hEE;
    tick();
    vec_cnt++; if (mem_enable !== 1'b1 || mem_write !== 1'b1) begin err_cnt++; $display("FAIL dma_wr_acc: en=%b wr=%b expected 1/1", mem_enable, mem_write); end
    vec_cnt++; if (mem_addr !== 16'h8001 || mem_wdata !== 8'h3C) begin err_cnt++; $display("FAIL dma_wr_bus: addr=%h data=%h expected 8001/3c", mem_addr, mem_wdata); end
    vec_cnt++; if (owner !== 1'b1) begin err_cnt++; $display("FAIL dma_wr_owner: got %b expected 1", owner); end
    tick();
    vec_cnt++; if (dma_ack !== 1'b1 || cpu_ack !== 1'b0) begin err_cnt++; $display("FAIL dma_wr_ack: dma=%b cpu=%b expected 1/0", dma_ack, cpu_ack); end
    vec_cnt++; if (dma_rdata !== 8'h00 || mem_write !== 1'b0) begin err_cnt++; $display("FAIL dma_wr_hold: rdata=%h wr=%b expected 00/0", dma_rdata, mem_write); end
    dma_req = 1'b0;
    tick();
  endtask

  task automatic test_dma_read();
    tick();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h4002; mem_rdata = 8'h5B;
    tick();
    vec_cnt++; if (mem_write !== 1'b0 || mem_addr !== 16'h4002) begin err_cnt++; $display("FAIL dma_rd_acc: wr=%b addr=%h expected 0/4002", mem_write, mem_addr); end
    tick();
    vec_cnt++; if (dma_ack !== 1'b1 || dma_rdata !== 8'h5B) begin err_cnt++; $display("FAIL dma_rd_ack: ack=%b rdata=%h expected 1/5b", dma_ack, dma_rdata); end
    vec_cnt++; if (cpu_rdata !== 8'hA5) begin err_cnt++; $display("FAIL dma_rd_cpu_hold: got %h expected a5", cpu_rdata); end
    dma_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    logic exp_q[$];
    logic exp_owner;
    int   grants;
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    grants = 0;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0A0A;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0B0B; mem_rdata = 8'h66;
    for (int k = 1; k <= 29; k++) begin
      tick();
      vec_cnt++; if (cpu_ack && dma_ack) begin err_cnt++; $display("FAIL starve_two_acks: cycle %0d both acks high", k); end
      vec_cnt++; if ((cpu_ack | dma_ack) !== ((k % 3) == 2)) begin err_cnt++; $display("FAIL starve_ack_timing: cycle %0d ack=%b expected %b", k, cpu_ack | dma_ack, (k % 3) == 2); end
      if ((k % 3) == 2 && exp_q.size() > 0) begin
        exp_owner = exp_q.pop_front();
        grants++;
        vec_cnt++; if (dma_ack !== exp_owner || cpu_ack !== ~exp_owner) begin err_cnt++; $display("FAIL starve_grant%0d: cpu=%b dma=%b expected dma=%b", grants, cpu_ack, dma_ack, exp_owner); end
        vec_cnt++; if (mem_addr !== (exp_owner ? 16'h0B0B : 16'h0A0A)) begin err_cnt++; $display("FAIL starve_addr%0d: got %h expected %h", grants, mem_addr, exp_owner ? 16'h0B0B : 16'h0A0A); end
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    vec_cnt++; if (grants != 10) begin err_cnt++; $display("FAIL starve_count: got %0d grants expected 10", grants); end
    tick();
  endtask

  task automatic test_reset_mid();
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2222; mem_rdata = 8'h77;
    tick();
    vec_cnt++; if (mem_enable !== 1'b1) begin err_cnt++; $display("FAIL rstmid_acc: got %b expected 1", mem_enable); end
    reset_n = 1'b0;
    #1;
    vec_cnt++; if (mem_enable !== 1'b0 || busy !== 1'b0 || cpu_ack !== 1'b0) begin err_cnt++; $display("FAIL rstmid_abort: en=%b busy=%b ack=%b expected 000", mem_enable, busy, cpu_ack); end
    vec_cnt++; if (cpu_rdata !== 8'h00) begin err_cnt++; $display("FAIL rstmid_rdata: got %h expected 00", cpu_rdata); end
    repeat (2) @(posedge cpu_clock);
    @(negedge cpu_clock);
    reset_n = 1'b1;
    tick();
    vec_cnt++; if (mem_enable !== 1'b1 || mem_addr !== 16'h2222 || cpu_ack !== 1'b0) begin err_cnt++; $display("FAIL rstmid_reacc: en=%b addr=%h ack=%b expected 1/2222/0", mem_enable, mem_addr, cpu_ack); end
    tick();
    vec_cnt++; if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h77) begin err_cnt++; $display("FAIL rstmid_ack: ack=%b rdata=%h expected 1/77", cpu_ack, cpu_rdata); end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; mem_rdata = 8'h10;
    tick();
    vec_cnt++; if (mem_enable !== 1'b1 || mem_addr !== 16'h0010) begin err_cnt++; $display("FAIL b2b_acc1: en=%b addr=%h expected 1/0010", mem_enable, mem_addr); end
    tick();
    vec_cnt++; if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h10) begin err_cnt++; $display("FAIL b2b_ack1: ack=%b rdata=%h expected 1/10", cpu_ack, cpu_rdata); end
    cpu_addr = 16'h0011; mem_rdata = 8'h11;
    tick();
    vec_cnt++; if (mem_enable !== 1'b0 || busy !== 1'b0 || cpu_ack !== 1'b0) begin err_cnt++; $display("FAIL b2b_idle: en=%b busy=%b ack=%b expected 000", mem_enable, busy, cpu_ack); end
    tick();
    vec_cnt++; if (mem_enable !== 1'b1 || mem_addr !== 16'h0011) begin err_cnt++; $display("FAIL b2b_acc2: en=%b addr=%h expected 1/0011", mem_enable, mem_addr); end
    tick();
    vec_cnt++; if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h11) begin err_cnt++; $display("FAIL b2b_ack2: ack=%b rdata=%h expected 1/11", cpu_ack, cpu_rdata); end
    cpu_req = 1'b0;
    tick();
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL b2b_end: busy=%b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_dma_read();
    test_starvation();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
